// File: rtl/button_scan_ctrl_if.sv
// Event stream from button_scan_ctrl to its consumer: FIFO head plus pop handshake.
interface button_scan_ctrl_if #(
    parameter int unsigned CH_W = 2
);
    logic            evt_valid;
    logic [CH_W-1:0] evt_ch;
    logic            evt_dir;
    logic            evt_ready;

    modport master (output evt_valid, output evt_ch, output evt_dir, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, input evt_dir, output evt_ready);
endinterface

// File: rtl/button_scan_ctrl.sv
// Round-robin multi-channel button debouncer with one shared evaluation engine,
// one-cycle edge pulses and a small event FIFO.
module button_scan_ctrl #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_div,
    input  logic [N_CH-1:0]    in,
    output logic [N_CH-1:0]    out,
    output logic [N_CH-1:0]    rise,
    output logic [N_CH-1:0]    fall,
    button_scan_ctrl_if.master evt,
    output logic               overflow
);
    localparam int unsigned FA_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FC_W = FA_W + 1;
    localparam int unsigned EV_W = CH_W + 1;

    typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_e;

    state_e           state_q, state_d;
    logic [N_CH-1:0]  sync_meta_q, sync_in_q;
    logic             clk_div_q;
    logic             tick;
    logic             tick_pending_q, tick_pending_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic             s_q, s_d, o_q, o_d;
    logic [CNT_W-1:0] c_q, c_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  out_q, out_d, rise_q, rise_d, fall_q, fall_d;
    logic             push;
    logic [EV_W-1:0]  push_data;

    logic [EV_W-1:0]  mem_q [FIFO_DEPTH];
    logic [EV_W-1:0]  mem_d [FIFO_DEPTH];
    logic [FA_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FC_W-1:0]  count_q, count_d;
    logic             pop, full;
    logic             evt_valid_q, evt_valid_d, evt_dir_q, evt_dir_d;
    logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
    logic             overflow_q, overflow_d;

    assign tick = clk_div & ~clk_div_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            sync_meta_q    <= '0;
            sync_in_q      <= '0;
            clk_div_q      <= 1'b0;
            tick_pending_q <= 1'b0;
            ptr_q          <= '0;
            s_q            <= 1'b0;
            o_q            <= 1'b0;
            c_q            <= '0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
            out_q          <= '0;
            rise_q         <= '0;
            fall_q         <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            evt_valid_q    <= 1'b0;
            evt_dir_q      <= 1'b0;
            evt_ch_q       <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_meta_q    <= in;
            sync_in_q      <= sync_meta_q;
            clk_div_q      <= clk_div;
            tick_pending_q <= tick_pending_d;
            ptr_q          <= ptr_d;
            s_q            <= s_d;
            o_q            <= o_d;
            c_q            <= c_d;
            cnt_q          <= cnt_d;
            out_q          <= out_d;
            rise_q         <= rise_d;
            fall_q         <= fall_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            evt_valid_q    <= evt_valid_d;
            evt_dir_q      <= evt_dir_d;
            evt_ch_q       <= evt_ch_d;
            overflow_q     <= overflow_d;
        end
    end

    // Scan engine: snapshot the channel in EVAL, resolve it in COMMIT
    always_comb begin
        state_d        = state_q;
        tick_pending_d = tick_pending_q;
        ptr_d          = ptr_q;
        s_d            = s_q;
        o_d            = o_q;
        c_d            = c_q;
        cnt_d          = cnt_q;
        out_d          = out_q;
        rise_d         = '0;
        fall_d         = '0;
        push           = 1'b0;
        push_data      = '0;
        case (state_q)
            IDLE: begin
                if (tick || tick_pending_q) begin
                    state_d        = EVAL;
                    tick_pending_d = 1'b0;
                end
            end
            EVAL: begin
                if (tick) tick_pending_d = 1'b1;
                s_d     = sync_in_q[ptr_q];
                o_d     = out_q[ptr_q];
                c_d     = cnt_q[ptr_q];
                state_d = COMMIT;
            end
            COMMIT: begin
                if (tick) tick_pending_d = 1'b1;
                if (s_q == o_q) begin
                    cnt_d[ptr_q] = '0;
                end else if (c_q == CNT_W'(STABLE_CNT - 1)) begin
                    out_d[ptr_q]  = s_q;
                    cnt_d[ptr_q]  = '0;
                    rise_d[ptr_q] = s_q;
                    fall_d[ptr_q] = ~s_q;
                    push          = 1'b1;
                    push_data     = {s_q, ptr_q};
                end else begin
                    cnt_d[ptr_q] = c_q + 1'b1;
                end
                ptr_d   = (ptr_q == CH_W'(N_CH - 1)) ? '0 : ptr_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Event FIFO; when full, a same-cycle pop frees the slot the push lands in
    always_comb begin
        pop        = (count_q != '0) && evt.evt_ready;
        full       = (count_q == FC_W'(FIFO_DEPTH));
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            if (full && !pop) begin
                overflow_d = 1'b1;
            end else begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
                count_d         = count_d + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_d - 1'b1;
        end
        evt_valid_d           = (count_d != '0);
        {evt_dir_d, evt_ch_d} = mem_d[rd_ptr_d];
    end

    assign out           = out_q;
    assign rise          = rise_q;
    assign fall          = fall_q;
    assign overflow      = overflow_q;
    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_ch    = evt_ch_q;
    assign evt.evt_dir   = evt_dir_q;
endmodule

// File: tb/tb_button_scan_ctrl.sv
// Directed bench for button_scan_ctrl: reset, press/release, bounce, FIFO overflow and push/pop.
module tb_button_scan_ctrl;
    localparam int unsigned N_CH = 4;
    localparam int unsigned CH_W = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            clk_div;
    logic [N_CH-1:0] in_v;
    logic [N_CH-1:0] out, rise, fall;
    logic            overflow;
    int              rise_cnt [N_CH];
    int              fall_cnt [N_CH];
    int              n_checks = 0;
    int              n_errors = 0;
    int              r0, r1, r2, f0, f2;

    button_scan_ctrl_if #(.CH_W(CH_W)) evt_if ();

    button_scan_ctrl #(
        .N_CH(N_CH), .CH_W(CH_W), .STABLE_CNT(4), .CNT_W(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .clk_div(clk_div), .in(in_v),
        .out(out), .rise(rise), .fall(fall), .evt(evt_if), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Count every cycle each pulse output is high
    always @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            rise_cnt[i] <= rise_cnt[i] + (rise[i] ? 1 : 0);
            fall_cnt[i] <= fall_cnt[i] + (fall[i] ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clk_div period of 4 clk; called and returns on a falling clk edge
    task automatic do_tick();
        clk_div = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clk_div = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic tick_with_pop();
        clk_div = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clk_div = 1'b0;
        evt_if.evt_ready = 1'b1;
        @(negedge clk);
        evt_if.evt_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_in(input logic [N_CH-1:0] v);
        in_v = v;
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_one();
        evt_if.evt_ready = 1'b1;
        @(negedge clk);
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clk_div = 1'b0;
        in_v = '0;
        evt_if.evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clk_div = 1'b0;
        in_v = '0;
        evt_if.evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out",      32'(out), 32'h0);
        check("rst_rise",     32'(rise), 32'h0);
        check("rst_fall",     32'(fall), 32'h0);
        check("rst_valid",    32'(evt_if.evt_valid), 32'h0);
        check("rst_ch",       32'(evt_if.evt_ch), 32'h0);
        check("rst_dir",      32'(evt_if.evt_dir), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a committing evaluation
        set_in(4'b1111);
        repeat (13) do_tick();
        check("prerst_out",   32'(out), 32'h1);
        check("prerst_valid", 32'(evt_if.evt_valid), 32'h1);
        r0 = rise_cnt[0];
        r1 = rise_cnt[1];
        clk_div = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clk_div = 1'b0;
        #1;
        check("midrst_out",   32'(out), 32'h0);
        check("midrst_valid", 32'(evt_if.evt_valid), 32'h0);
        check("midrst_rise",  32'(rise), 32'h0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        repeat (12) do_tick();
        check("postrst_out12", 32'(out), 32'h0);
        do_tick();
        check("postrst_out13",   32'(out), 32'h1);
        check("postrst_rise0",   32'(rise_cnt[0] - r0), 32'h1);
        check("postrst_norise1", 32'(rise_cnt[1] - r1), 32'h0);

        // Clean press on channel 2
        do_reset();
        r2 = rise_cnt[2];
        f2 = fall_cnt[2];
        set_in(4'b0100);
        repeat (14) do_tick();
        check("press_out14", 32'(out), 32'h0);
        do_tick();
        check("press_out15", 32'(out), 32'h4);
        check("press_rise",  32'(rise_cnt[2] - r2), 32'h1);
        check("press_nofall", 32'(fall_cnt[2] - f2), 32'h0);
        check("press_valid", 32'(evt_if.evt_valid), 32'h1);
        check("press_ch",    32'(evt_if.evt_ch), 32'h2);
        check("press_dir",   32'(evt_if.evt_dir), 32'h1);

        // Release of channel 2
        set_in(4'b0000);
        repeat (15) do_tick();
        check("rel_out30", 32'(out), 32'h4);
        do_tick();
        check("rel_out31",  32'(out), 32'h0);
        check("rel_fall",   32'(fall_cnt[2] - f2), 32'h1);
        check("rel_head_ch",  32'(evt_if.evt_ch), 32'h2);
        check("rel_head_dir", 32'(evt_if.evt_dir), 32'h1);
        pop_one();
        check("rel_valid2", 32'(evt_if.evt_valid), 32'h1);
        check("rel_ch2",    32'(evt_if.evt_ch), 32'h2);
        check("rel_dir2",   32'(evt_if.evt_dir), 32'h0);
        pop_one();
        check("rel_empty",  32'(evt_if.evt_valid), 32'h0);

        // Bounce on channel 1: high, high, low, then steady high
        do_reset();
        r1 = rise_cnt[1];
        set_in(4'b0010);
        repeat (8) do_tick();
        set_in(4'b0000);
        repeat (4) do_tick();
        set_in(4'b0010);
        repeat (13) do_tick();
        check("bounce_out25",   32'(out), 32'h0);
        check("bounce_valid25", 32'(evt_if.evt_valid), 32'h0);
        do_tick();
        check("bounce_out26", 32'(out), 32'h2);
        check("bounce_rise",  32'(rise_cnt[1] - r1), 32'h1);
        check("bounce_valid", 32'(evt_if.evt_valid), 32'h1);
        check("bounce_ch",    32'(evt_if.evt_ch), 32'h1);
        check("bounce_dir",   32'(evt_if.evt_dir), 32'h1);
        pop_one();
        check("bounce_one_evt", 32'(evt_if.evt_valid), 32'h0);

        // FIFO overflow: five commits with no consumer
        do_reset();
        set_in(4'b1111);
        repeat (16) do_tick();
        check("ovf_out16",  32'(out), 32'hf);
        check("ovf_head",   32'(evt_if.evt_ch), 32'h0);
        check("ovf_clear",  32'(overflow), 32'h0);
        f0 = fall_cnt[0];
        set_in(4'b0000);
        repeat (12) do_tick();
        check("ovf_clear28", 32'(overflow), 32'h0);
        do_tick();
        check("ovf_set",   32'(overflow), 32'h1);
        check("ovf_out29", 32'(out), 32'he);
        check("ovf_fall0", 32'(fall_cnt[0] - f0), 32'h1);
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_valid", 32'(evt_if.evt_valid), 32'h1);
            check("ovf_drain_ch",    32'(evt_if.evt_ch), 32'(i));
            check("ovf_drain_dir",   32'(evt_if.evt_dir), 32'h1);
            @(negedge clk);
        end
        evt_if.evt_ready = 1'b0;
        check("ovf_empty",  32'(evt_if.evt_valid), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Full FIFO with a pop in the same cycle as the push
        do_reset();
        set_in(4'b1111);
        repeat (16) do_tick();
        set_in(4'b0000);
        repeat (12) do_tick();
        tick_with_pop();
        check("pp_overflow", 32'(overflow), 32'h0);
        check("pp_valid",    32'(evt_if.evt_valid), 32'h1);
        check("pp_out",      32'(out), 32'he);
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pp_drain_valid", 32'(evt_if.evt_valid), 32'h1);
            check("pp_drain_ch",    32'(evt_if.evt_ch), 32'((i + 1) % 4));
            check("pp_drain_dir",   32'(evt_if.evt_dir), (i < 3) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        evt_if.evt_ready = 1'b0;
        check("pp_empty",    32'(evt_if.evt_valid), 32'h0);
        check("pp_no_ovf",   32'(overflow), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/button_scan_ctrl.md
# button_scan_ctrl

Time-multiplexed debounce controller serving N_CH raw push-button inputs with one shared evaluation engine, paced by the `clock_divider` output. Each divided-clock tick services exactly one channel in round-robin order. The engine updates that channel's stable-sample counter and commits debounced level changes. Every committed change produces a one-cycle edge pulse and an entry in a small event FIFO, read by downstream logic (LED/display control) through a valid/ready handshake.

## Interface
- N_CH, 4: number of button channels (2..8)
- CH_W, 2: channel index width; must equal clog2(N_CH)
- STABLE_CNT, 4: consecutive disagreeing samples required to commit a change (2..7)
- CNT_W, 3: per-channel counter width; must satisfy 2^CNT_W > STABLE_CNT
- FIFO_DEPTH, 4: event FIFO entries (power of 2)
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clk_div  in  1  divided clock from `clock_divider`, synchronous to clk; rising edge = tick
- in  in  N_CH  raw button levels, asynchronous
- out  out  N_CH  debounced levels
- rise  out  N_CH  one-cycle pulse on committed 0->1
- fall  out  N_CH  one-cycle pulse on committed 1->0
- evt_valid  out  1  FIFO non-empty
- evt_ch  out  CH_W  channel of head event
- evt_dir  out  1  head event direction, 1 = rise
- evt_ready  in  1  consumer pops head when evt_valid & evt_ready
- overflow  out  1  sticky: an event was dropped on full FIFO

## Operation
- `in` passes through a 2-flop synchronizer (sync_in) before any use.
- Tick detection: clk_div_q registers clk_div; tick = clk_div & ~clk_div_q.
- Scan pointer ptr (CH_W bits, reset 0) selects the serviced channel. It increments at COMMIT and wraps N_CH-1 -> 0. A given channel is therefore sampled every N_CH ticks.
- FSM states:
  - IDLE: on tick or tick_pending -> EVAL; clear tick_pending.
  - EVAL: latch s = sync_in[ptr], o = out[ptr], c = cnt[ptr] -> COMMIT.
  - COMMIT:
    - If s == o: cnt[ptr] <= 0.
    - Else if c == STABLE_CNT-1: out[ptr] <= s; cnt[ptr] <= 0; pulse rise/fall[ptr]; push {s, ptr}.
    - Else: cnt[ptr] <= c+1.
    - Then increment ptr -> IDLE.
- A tick arriving in EVAL or COMMIT sets tick_pending. A further tick while tick_pending is already set is lost.
- Counter never exceeds STABLE_CNT-1; no wrap possible.
- FIFO:
  - Push when full without a same-cycle pop: the event is dropped and overflow is set. Overflow is cleared only by rst.
  - Full with simultaneous pop and push: both happen; count unchanged, no overflow.
  - Empty with push: evt_valid rises the next cycle (no fall-through).
  - evt_ready while empty is ignored.
- Reset (any time, including mid-EVAL/COMMIT) takes effect immediately and discards any in-flight evaluation.
  - Reset values: out=0, rise=0, fall=0, all cnt=0, ptr=0, state=IDLE, tick_pending=0, sync flops=0, clk_div_q=0, FIFO empty, evt_valid=0, evt_ch=0, evt_dir=0, overflow=0.

## Timing
- Tick seen in cycle C (state IDLE) -> EVAL at C+1 -> COMMIT at C+2 -> out, rise/fall, FIFO write visible at C+3. rise/fall are high for cycle C+3 only.
- Input-to-sample latency: 2 clk (synchronizer) plus wait for the channel's scan slot.
- Worst-case commit latency after a clean level change: (STABLE_CNT × N_CH) ticks + 5 clk.
- Minimum clk_div period: 4 clk for lossless ticks. The clock_divider configuration guarantees this.
- evt_ch and evt_dir are stable while evt_valid=1 and evt_ready=0. Pop takes effect at the clock edge; the next entry appears in the following cycle.

## Test plan
- Reset: assert rst 100 ns mid-COMMIT with in=4'b1111 -> all outputs 0 immediately, ptr=0 on release, no pulse emitted.
- Clean press: defaults, in[2] 0->1 held -> out[2]=1 after the 4th ch2 service (tick 15 from ptr=0, given the 2-clk synchronizer settles before tick 3). Single rise[2] pulse; FIFO holds {dir=1, ch=2}; no change on other channels.
- Bounce rejection: in[1] high for 2 ch1 samples, low for 1, high again -> counter restarts. out[1] commits only after 4 uninterrupted high samples; exactly one event.
- Release: after the press test, in[2] -> 0 held -> out[2]=0, one fall[2] pulse, event {0, 2}.
- FIFO full/overflow: evt_ready=0, generate 5 commits -> 4 entries, overflow=1. Then evt_ready=1 -> events pop in commit order, evt_valid drops after the 4th pop, overflow stays 1.
- Simultaneous push/pop: FIFO full, evt_ready=1 in the commit's C+2 cycle -> no overflow, count remains 4, new event appears at the tail.
